// File: rtl/dbus_timer_slave_pkg.sv
// Shared definitions for the data-bus machine timer: bus widths, register
// offsets, control bit positions, handshake FSM encoding, byte-merge helper.
package dbus_timer_slave_pkg;

  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_DATA_W  = 32;
  localparam int DBUS_MASK_W = 4;

  localparam logic [7:0] TMR_OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] TMR_OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] TMR_OFF_MTCMP_LO = 8'h08;
  localparam logic [7:0] TMR_OFF_MTCMP_HI = 8'h0C;
  localparam logic [7:0] TMR_OFF_CTRL     = 8'h10;
  localparam logic [7:0] TMR_OFF_PRESC    = 8'h14;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic                   we;
    logic [MEM_ADDR_W-1:0]  addr;
    logic [MEM_DATA_W-1:0]  wdata;
    logic [DBUS_MASK_W-1:0] mask;
  } dbus_req_t;

  // Replace the bytes of old selected by mask with the matching bytes of wdata.
  function automatic logic [MEM_DATA_W-1:0] byte_merge(
    input logic [MEM_DATA_W-1:0]  old,
    input logic [MEM_DATA_W-1:0]  wdata,
    input logic [DBUS_MASK_W-1:0] mask
  );
    logic [MEM_DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < DBUS_MASK_W; i++)
      if (mask[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dbus_timer_slave_resp_fsm.sv
// Responder handshake: IDLE -> (WAIT x WAIT_CYCLES) -> RESP -> IDLE.
// access is high for exactly the RESP cycle; it doubles as ready and as
// the commit strobe for writes.
module bus_resp_fsm
  import dbus_timer_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic access
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_state_e state, state_d;
  logic [3:0] wcnt, wcnt_d;

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
    end
  end

  // Next state; a dropped request in WAIT aborts without a response.
  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    case (state)
      ST_IDLE: if (req) begin
        if (WAIT_CYCLES > 0) begin
          state_d = ST_WAIT;
          wcnt_d  = WAIT_LOAD;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!req)            state_d = ST_IDLE;
        else if (wcnt == '0) state_d = ST_RESP;
        else                 wcnt_d  = wcnt - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign access = (state == ST_RESP);

endmodule

// File: rtl/dbus_timer_slave.sv
// Memory-mapped machine timer on the data bus: 64-bit mtime/mtimecmp,
// enable/interrupt-enable control, prescaler, registered level interrupt.
module dbus_timer_slave
  import dbus_timer_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter int          PRESCALE_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dbus_req,
  input  logic                   dbus_we,
  input  logic [MEM_ADDR_W-1:0]  dbus_addr,
  input  logic [MEM_DATA_W-1:0]  dbus_wdata,
  input  logic [DBUS_MASK_W-1:0] dbus_mask,
  output logic [MEM_DATA_W-1:0]  dbus_rdata,
  output logic                   dbus_ready,
  output logic                   timer_int
);

  logic                  access;
  dbus_req_t             rq;
  logic                  hit;
  logic [7:0]            off;
  logic                  wr_en;
  logic                  wr_mtime_lo, wr_mtime_hi, wr_mtcmp_lo, wr_mtcmp_hi;
  logic                  wr_ctrl, wr_presc;
  logic [63:0]           mtime, mtimecmp;
  logic                  ctrl_en, ctrl_ie;
  logic [PRESCALE_W-1:0] presc, presc_cnt;
  logic                  tick;
  logic [MEM_DATA_W-1:0] rd_mux;

  bus_resp_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .req    (dbus_req),
    .access (access)
  );

  assign rq  = '{we: dbus_we, addr: dbus_addr, wdata: dbus_wdata, mask: dbus_mask};
  assign hit = (rq.addr[31:8] == BASE_ADDR[31:8]);
  assign off = rq.addr[7:0] & 8'hFC;

  // A zero mask is a true no-op, so it must not suppress the mtime increment.
  assign wr_en       = access & rq.we & hit & (|rq.mask);
  assign wr_mtime_lo = wr_en && (off == TMR_OFF_MTIME_LO);
  assign wr_mtime_hi = wr_en && (off == TMR_OFF_MTIME_HI);
  assign wr_mtcmp_lo = wr_en && (off == TMR_OFF_MTCMP_LO);
  assign wr_mtcmp_hi = wr_en && (off == TMR_OFF_MTCMP_HI);
  assign wr_ctrl     = wr_en && (off == TMR_OFF_CTRL);
  assign wr_presc    = wr_en && (off == TMR_OFF_PRESC);

  assign tick = ctrl_en && (presc_cnt == presc);

  // Read mux over pre-update register values; unmapped offsets read 0.
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (off)
        TMR_OFF_MTIME_LO: rd_mux = mtime[31:0];
        TMR_OFF_MTIME_HI: rd_mux = mtime[63:32];
        TMR_OFF_MTCMP_LO: rd_mux = mtimecmp[31:0];
        TMR_OFF_MTCMP_HI: rd_mux = mtimecmp[63:32];
        TMR_OFF_CTRL: begin
          rd_mux[CTRL_EN_BIT] = ctrl_en;
          rd_mux[CTRL_IE_BIT] = ctrl_ie;
        end
        TMR_OFF_PRESC:    rd_mux = MEM_DATA_W'(presc);
        default:          rd_mux = '0;
      endcase
    end
  end

  assign dbus_rdata = access ? rd_mux : '0;
  assign dbus_ready = access;

  // mtime: a bus write to either half wins over the increment that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime[31:0]  <= byte_merge(mtime[31:0],  rq.wdata, rq.mask);
      if (wr_mtime_hi) mtime[63:32] <= byte_merge(mtime[63:32], rq.wdata, rq.mask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Prescaler counter: cleared by a PRESC write, otherwise runs 0..PRESC.
  always_ff @(posedge clk) begin
    if (rst)          presc_cnt <= '0;
    else if (wr_presc) presc_cnt <= '0;
    else if (ctrl_en)  presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
  end

  // Software-visible compare, control and prescaler registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
      ctrl_en  <= 1'b0;
      ctrl_ie  <= 1'b0;
      presc    <= '0;
    end else begin
      if (wr_mtcmp_lo) mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0],  rq.wdata, rq.mask);
      if (wr_mtcmp_hi) mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], rq.wdata, rq.mask);
      if (wr_ctrl && rq.mask[0]) begin
        ctrl_en <= rq.wdata[CTRL_EN_BIT];
        ctrl_ie <= rq.wdata[CTRL_IE_BIT];
      end
      for (int b = 0; b < PRESCALE_W; b++)
        if (wr_presc && rq.mask[b/8]) presc[b] <= rq.wdata[b];
    end
  end

  // Registered level interrupt; lags register updates by one cycle.
  always_ff @(posedge clk) begin
    if (rst) timer_int <= 1'b0;
    else     timer_int <= ctrl_ie & (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_dbus_timer_slave.sv
// Directed bench: u_w0 has no wait states, u_w3 has WAIT_CYCLES=3.
module tb_dbus_timer_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, ready0, int0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  mask0;
  logic        req1, we1, ready1, int1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  mask1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_MTIME_LO = 32'h0200_0000;
  localparam logic [31:0] A_MTIME_HI = 32'h0200_0004;
  localparam logic [31:0] A_MTCMP_LO = 32'h0200_0008;
  localparam logic [31:0] A_MTCMP_HI = 32'h0200_000C;
  localparam logic [31:0] A_CTRL     = 32'h0200_0010;
  localparam logic [31:0] A_PRESC    = 32'h0200_0014;

  always #5 clk = ~clk;

  dbus_timer_slave #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .dbus_req(req0), .dbus_we(we0), .dbus_addr(addr0),
    .dbus_wdata(wdata0), .dbus_mask(mask0), .dbus_rdata(rdata0),
    .dbus_ready(ready0), .timer_int(int0)
  );

  dbus_timer_slave #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .dbus_req(req1), .dbus_we(we1), .dbus_addr(addr1),
    .dbus_wdata(wdata1), .dbus_mask(mask1), .dbus_rdata(rdata1),
    .dbus_ready(ready1), .timer_int(int1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus transaction; returns rdata at ready and cycles from req to ready.
  task automatic access(input int sel, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m,
                        output logic [31:0] rd, output int lat);
    logic got, r;
    logic [31:0] d;
    @(posedge clk); #1;
    if (sel == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; mask0 = m; end
    else          begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; mask1 = m; end
    got = 0; lat = 0; rd = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      r = (sel == 0) ? ready0 : ready1;
      d = (sel == 0) ? rdata0 : rdata1;
      if (r) begin got = 1; rd = d; end
      else begin chk("rdata_idle", d, 0); lat++; end
    end
    if (!got) begin
      checks++; errors++;
      $error("FAIL ready_timeout got=no_ready exp=ready");
    end
    @(posedge clk); #1;
    chk("ready_pulse", (sel == 0) ? ready0 : ready1, 0);
    if (sel == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic rd(input int sel, input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    int lat;
    access(sel, 1'b0, a, 32'h0, 4'h0, d, lat);
    chk({tag, "_lat"}, 64'(lat), (sel == 0) ? 64'd1 : 64'd4);
    chk(tag, d, exp);
  endtask

  task automatic wr(input int sel, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] d;
    int lat;
    access(sel, 1'b1, a, wd, m, d, lat);
    chk("wr_lat", 64'(lat), (sel == 0) ? 64'd1 : 64'd4);
  endtask

  initial begin
    rst = 1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; mask0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; mask1 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready0", ready0, 0); chk("rst_rdata0", rdata0, 0); chk("rst_int0", int0, 0);
    chk("rst_ready1", ready1, 0); chk("rst_rdata1", rdata1, 0); chk("rst_int1", int1, 0);

    // reset values, zero-wait latency
    rd(0, A_MTCMP_LO, 32'hFFFF_FFFF, "t1_mtcmp_lo");
    rd(0, A_MTCMP_HI, 32'hFFFF_FFFF, "t1_mtcmp_hi");
    rd(0, A_MTIME_LO, 32'h0, "t1_mtime_lo");
    rd(0, A_CTRL, 32'h0, "t1_ctrl");
    chk("t1_int", int0, 0);

    // byte merge, unmapped offset, out-of-window
    wr(0, A_MTCMP_LO, 32'hAABB_CCDD, 4'b0010);
    rd(0, A_MTCMP_LO, 32'hFFFF_CCFF, "t5_merge");
    wr(0, 32'h0200_0040, 32'h1234_5678, 4'hF);
    rd(0, 32'h0200_0040, 32'h0, "t5_unmapped");
    wr(0, 32'h0300_0008, 32'h0, 4'hF);
    rd(0, A_MTCMP_LO, 32'hFFFF_CCFF, "t5_outwin_wr");
    rd(0, 32'h0300_0008, 32'h0, "t5_outwin_rd");

    // counting with PRESC=0: EN committed at edge p2, read returns mtime after p14
    wr(0, A_PRESC, 32'h0, 4'hF);
    wr(0, A_CTRL, 32'h1, 4'hF);
    repeat (10) @(posedge clk);
    rd(0, A_MTIME_LO, 32'd12, "t3_count");
    rd(0, A_MTIME_HI, 32'd0, "t3_count_hi");

    // write/increment collision: written value, then two ticks before the read
    wr(0, A_MTIME_LO, 32'd100, 4'hF);
    rd(0, A_MTIME_LO, 32'd102, "collide");

    // interrupt assertion at mtime==20, removal by raising mtimecmp
    wr(0, A_CTRL, 32'h0, 4'hF);
    wr(0, A_MTIME_LO, 32'h0, 4'hF);
    wr(0, A_MTIME_HI, 32'h0, 4'hF);
    wr(0, A_MTCMP_LO, 32'd20, 4'hF);
    wr(0, A_MTCMP_HI, 32'h0, 4'hF);
    wr(0, A_CTRL, 32'h3, 4'hF);
    repeat (20) @(posedge clk);
    @(negedge clk); chk("t4_int_before", int0, 0);
    @(posedge clk); @(negedge clk); chk("t4_int_rise", int0, 1);
    wr(0, A_MTCMP_HI, 32'h1, 4'hF);
    @(negedge clk); chk("t4_int_lag", int0, 1);
    @(posedge clk); @(negedge clk); chk("t4_int_drop", int0, 0);

    // 64-bit wrap
    wr(0, A_CTRL, 32'h0, 4'hF);
    wr(0, A_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    wr(0, A_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    wr(0, A_CTRL, 32'h1, 4'hF);
    rd(0, A_MTIME_HI, 32'h0, "t6_wrap_hi");
    rd(0, A_MTIME_LO, 32'd3, "t6_wrap_lo");

    // wait states
    rd(1, A_CTRL, 32'h0, "t2_ctrl_w3");
    wr(1, A_PRESC, 32'h0000_1234, 4'b0011);
    rd(1, A_PRESC, 32'h0000_1234, "t2_presc_w3");

    // abort in WAIT: no ready, no write
    @(posedge clk); #1;
    req1 = 1; we1 = 1; addr1 = A_CTRL; wdata1 = 32'h3; mask1 = 4'hF;
    @(posedge clk); @(posedge clk); #1 req1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t6_abort_ready", ready1, 0);
    end
    rd(1, A_CTRL, 32'h0, "t6_abort_ctrl");

    // reset in WAIT: no ready, registers back to reset values
    wr(1, A_CTRL, 32'h1, 4'hF);
    @(posedge clk); #1;
    req1 = 1; we1 = 1; addr1 = A_CTRL; wdata1 = 32'h3; mask1 = 4'hF;
    @(posedge clk); @(posedge clk); #1 rst = 1;
    @(posedge clk); @(negedge clk);
    chk("t6_rst_ready", ready1, 0);
    chk("t6_rst_rdata", rdata1, 0);
    rst = 0; req1 = 0;
    rd(1, A_CTRL, 32'h0, "t6_rst_ctrl");
    rd(0, A_MTCMP_HI, 32'hFFFF_FFFF, "t6_rst_mtcmp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
